// File: rtl/rom_load_ctrl.sv
// ROM/aux download controller: routes ioctl ROM bytes to the core, latches variant/DIP bytes, sequences core reset.
// Optional checksum of accepted ROM bytes on rom_sum when ROMLOAD_CHECKSUM_EN is defined.
module rom_load_ctrl #(
  parameter int SETTLE_CYCLES = 256,
  parameter int ROM_MIN_BYTES = 16384
) (
  input  logic        clk_sys,
  input  logic        I_RESET,
  input  logic        usr_reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        dn_wr,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        core_reset,
  output logic [7:0]  mod,
  output logic [7:0]  dip0,
  output logic [7:0]  dip1,
  output logic [7:0]  dip2,
  output logic        rom_err,
  output logic [7:0]  rom_sum
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD_ROM, LOAD_AUX, SETTLE, RUN} state_t;

  state_t        state, state_next;
  logic          aux_from_run, aux_dip;
  logic          dl_hold;
  logic [16:0]   byte_cnt, cnt_next;
  logic          ovf, ovf_next;
  logic [SW-1:0] settle_cnt;
  logic          rom_wr, rom_acc, rom_drop;
  logic          dl_new, idx_rom, idx_aux;
  logic          rom_start, rom_fail, aux_start, settle_clr;

  assign rom_wr   = (state == LOAD_ROM) && ioctl_wr;
  assign rom_acc  = rom_wr && (ioctl_addr[24:16] == '0);
  assign rom_drop = rom_wr && (ioctl_addr[24:16] != '0);
  // The byte on the falling-download cycle is folded in before the length check.
  assign cnt_next = (rom_acc && (byte_cnt != '1)) ? byte_cnt + 17'd1 : byte_cnt;
  assign ovf_next = ovf | rom_drop;
  // A download still active when reset releases is not treated as a new one.
  assign dl_new   = ioctl_download && !dl_hold;
  assign idx_rom  = (ioctl_index == 8'd0);
  assign idx_aux  = (ioctl_index == 8'd1) || (ioctl_index == 8'd254);

  always_ff @(posedge clk_sys or posedge I_RESET) begin
    if (I_RESET) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    core_reset = 1'b1;
    rom_start  = 1'b0;
    rom_fail   = 1'b0;
    aux_start  = 1'b0;
    settle_clr = 1'b0;
    case (state)
      IDLE, RUN: begin
        core_reset = (state != RUN);
        if (dl_new && idx_rom) begin
          state_next = LOAD_ROM;
          rom_start  = 1'b1;
          core_reset = 1'b1;
        end else if (dl_new && idx_aux) begin
          state_next = LOAD_AUX;
          aux_start  = 1'b1;
        end else if ((state == RUN) && usr_reset) begin
          state_next = SETTLE;
          settle_clr = 1'b1;
        end
      end
      LOAD_ROM: begin
        if (!ioctl_download) begin
          if ((32'(cnt_next) >= 32'(ROM_MIN_BYTES)) && !ovf_next) begin
            state_next = SETTLE;
            settle_clr = 1'b1;
          end else begin
            state_next = IDLE;
            rom_fail   = 1'b1;
          end
        end
      end
      LOAD_AUX: begin
        core_reset = !aux_from_run;
        if (!ioctl_download) state_next = aux_from_run ? RUN : IDLE;
      end
      SETTLE: begin
        if (usr_reset)                        settle_clr = 1'b1;
        else if (settle_cnt == SETTLE_LAST)   state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge I_RESET) begin
    if (I_RESET) begin
      dl_hold      <= 1'b1;
      dn_wr        <= 1'b0;
      dn_addr      <= '0;
      dn_data      <= '0;
      byte_cnt     <= '0;
      ovf          <= 1'b0;
      rom_err      <= 1'b0;
      aux_from_run <= 1'b0;
      aux_dip      <= 1'b0;
      mod          <= '0;
      dip0         <= '1;
      dip1         <= '1;
      dip2         <= '1;
      settle_cnt   <= '0;
    end else begin
      if (!ioctl_download) dl_hold <= 1'b0;
      dn_wr <= rom_acc;
      if (rom_acc) begin
        dn_addr <= ioctl_addr[15:0];
        dn_data <= ioctl_dout;
      end
      if (rom_start) begin
        byte_cnt <= '0;
        ovf      <= 1'b0;
        rom_err  <= 1'b0;
      end else if (state == LOAD_ROM) begin
        byte_cnt <= cnt_next;
        ovf      <= ovf_next;
      end
      if (rom_fail) rom_err <= 1'b1;
      if (aux_start) begin
        aux_from_run <= (state == RUN);
        aux_dip      <= (ioctl_index == 8'd254);
      end
      if ((state == LOAD_AUX) && ioctl_wr) begin
        if (!aux_dip)                     mod  <= ioctl_dout;
        else if (ioctl_addr == 25'd0)     dip0 <= ioctl_dout;
        else if (ioctl_addr == 25'd1)     dip1 <= ioctl_dout;
        else if (ioctl_addr == 25'd2)     dip2 <= ioctl_dout;
      end
      if (settle_clr)            settle_cnt <= '0;
      else if (state == SETTLE)  settle_cnt <= settle_cnt + 1'b1;
    end
  end

`ifdef ROMLOAD_CHECKSUM_EN
  always_ff @(posedge clk_sys or posedge I_RESET) begin
    if (I_RESET)        rom_sum <= '0;
    else if (rom_start) rom_sum <= '0;
    else if (rom_acc)   rom_sum <= rom_sum + ioctl_dout;
  end
`else
  assign rom_sum = '0;
`endif

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed bench for rom_load_ctrl at default parameters; checksum scenario runs when ROMLOAD_CHECKSUM_EN is defined.
module tb_rom_load_ctrl;

  logic        clk_sys = 1'b0;
  logic        I_RESET = 1'b1;
  logic        usr_reset = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        dn_wr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        core_reset;
  logic [7:0]  mod, dip0, dip1, dip2;
  logic        rom_err;
  logic [7:0]  rom_sum;

  int vectors = 0;
  int errors  = 0;

  rom_load_ctrl #(.SETTLE_CYCLES(256), .ROM_MIN_BYTES(16384)) dut (
    .clk_sys(clk_sys), .I_RESET(I_RESET), .usr_reset(usr_reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data), .core_reset(core_reset),
    .mod(mod), .dip0(dip0), .dip1(dip1), .dip2(dip2),
    .rom_err(rom_err), .rom_sum(rom_sum)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic burst(input int base, input int n, input logic [7:0] d, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(base + i); ioctl_dout = d;
      tick;
      if (dn_wr === 1'b1) seen++;
    end
    ioctl_wr = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) tick;
    vectors++; if (core_reset !== 1'b1) begin errors++; $display("FAIL reset_core_reset got %0b want 1", core_reset); end
    vectors++; if (dn_wr !== 1'b0 || dn_addr !== 16'h0 || dn_data !== 8'h0) begin errors++; $display("FAIL reset_dn got %0b/%h/%h want 0/0000/00", dn_wr, dn_addr, dn_data); end
    vectors++; if (mod !== 8'h00 || dip0 !== 8'hFF || dip1 !== 8'hFF || dip2 !== 8'hFF) begin errors++; $display("FAIL reset_aux got %h/%h/%h/%h want 00/ff/ff/ff", mod, dip0, dip1, dip2); end
    vectors++; if (rom_err !== 1'b0 || rom_sum !== 8'h00) begin errors++; $display("FAIL reset_err_sum got %0b/%h want 0/00", rom_err, rom_sum); end
    I_RESET = 1'b0;
    repeat (3) tick;
  endtask

  task automatic test_rom_good;
    int bad = 0, pulses = 0, n = 0;
    logic [7:0] d, exp_sum = 8'h00;
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    tick;
    vectors++; if (core_reset !== 1'b1) begin errors++; $display("FAIL good_load_core_reset got %0b want 1", core_reset); end
    for (int i = 0; i < 16383; i++) begin
      d = 8'(i) ^ 8'h5A;
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = d;
      tick;
      if (dn_wr === 1'b1) pulses++;
      if (dn_wr !== 1'b1 || dn_addr !== 16'(i) || dn_data !== d) bad++;
      exp_sum = exp_sum + d;
      ioctl_wr = 1'b0;
      tick;
      if (dn_wr !== 1'b0) bad++;
    end
    vectors++; if (bad != 0) begin errors++; $display("FAIL good_dn_stream got %0d bad cycles want 0", bad); end
    vectors++; if (pulses != 16383) begin errors++; $display("FAIL good_dn_pulses got %0d want 16383", pulses); end
    // last byte lands on the same cycle the download drops
    ioctl_wr = 1'b1; ioctl_addr = 25'd16383; ioctl_dout = 8'hC3; ioctl_download = 1'b0;
    exp_sum = exp_sum + 8'hC3;
    tick;
    ioctl_wr = 1'b0;
    vectors++; if (dn_wr !== 1'b1 || dn_addr !== 16'h3FFF || dn_data !== 8'hC3) begin errors++; $display("FAIL good_tail_byte got %0b/%h/%h want 1/3fff/c3", dn_wr, dn_addr, dn_data); end
    for (int i = 0; i < 1000; i++) begin
      if (core_reset !== 1'b1) break;
      n++;
      tick;
    end
    vectors++; if (n != 256) begin errors++; $display("FAIL good_settle_len got %0d want 256", n); end
    vectors++; if (core_reset !== 1'b0 || rom_err !== 1'b0) begin errors++; $display("FAIL good_run got core_reset=%0b rom_err=%0b want 0/0", core_reset, rom_err); end
`ifndef ROMLOAD_CHECKSUM_EN
    exp_sum = 8'h00;
`endif
    vectors++; if (rom_sum !== exp_sum) begin errors++; $display("FAIL good_rom_sum got %h want %h", rom_sum, exp_sum); end
  endtask

  task automatic test_aux_dip;
    int wr_seen = 0, cr_bad = 0;
    logic [7:0] vals [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    ioctl_index = 8'd254; ioctl_download = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = vals[i];
      tick;
      if (dn_wr !== 1'b0) wr_seen++;
      if (core_reset !== 1'b0) cr_bad++;
      ioctl_wr = 1'b0;
      tick;
      if (dn_wr !== 1'b0) wr_seen++;
      if (core_reset !== 1'b0) cr_bad++;
    end
    ioctl_download = 1'b0;
    tick;
    vectors++; if (dip0 !== 8'h12 || dip1 !== 8'h34 || dip2 !== 8'h56) begin errors++; $display("FAIL dip_values got %h/%h/%h want 12/34/56", dip0, dip1, dip2); end
    vectors++; if (wr_seen != 0) begin errors++; $display("FAIL dip_no_dn_wr got %0d pulses want 0", wr_seen); end
    vectors++; if (cr_bad != 0 || core_reset !== 1'b0) begin errors++; $display("FAIL dip_core_reset got %0d high cycles want 0", cr_bad); end
    vectors++; if (mod !== 8'h00) begin errors++; $display("FAIL dip_mod_hold got %h want 00", mod); end
  endtask

  task automatic test_aux_mod;
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    tick;
    ioctl_wr = 1'b1; ioctl_addr = 25'd5; ioctl_dout = 8'h03; tick;
    ioctl_wr = 1'b0; tick;
    ioctl_wr = 1'b1; ioctl_addr = 25'd9; ioctl_dout = 8'h0B; tick;
    ioctl_wr = 1'b0; ioctl_download = 1'b0; tick;
    vectors++; if (mod !== 8'h0B) begin errors++; $display("FAIL mod_last_wins got %h want 0b", mod); end
    vectors++; if (core_reset !== 1'b0 || dip0 !== 8'h12) begin errors++; $display("FAIL mod_side_effects got core_reset=%0b dip0=%h want 0/12", core_reset, dip0); end
  endtask

  task automatic test_ignored_index;
    ioctl_index = 8'd7; ioctl_download = 1'b1;
    tick;
    ioctl_wr = 1'b1; ioctl_addr = 25'd0; ioctl_dout = 8'hEE;
    tick;
    ioctl_wr = 1'b0;
    vectors++; if (dn_wr !== 1'b0 || core_reset !== 1'b0) begin errors++; $display("FAIL ignored_idx got dn_wr=%0b core_reset=%0b want 0/0", dn_wr, core_reset); end
    ioctl_download = 1'b0;
    tick;
    vectors++; if (mod !== 8'h0B || dip0 !== 8'h12) begin errors++; $display("FAIL ignored_idx_hold got mod=%h dip0=%h want 0b/12", mod, dip0); end
  endtask

  task automatic test_usr_reset;
    int n = 0;
    usr_reset = 1'b1;
    tick;
    usr_reset = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (core_reset !== 1'b1) break;
      n++;
      if (n == 100) usr_reset = 1'b1;
      tick;
      usr_reset = 1'b0;
    end
    vectors++; if (n != 356) begin errors++; $display("FAIL usr_reset_settle got %0d want 356", n); end
    vectors++; if (core_reset !== 1'b0) begin errors++; $display("FAIL usr_reset_run got %0b want 0", core_reset); end
  endtask

  task automatic test_rom_short;
    int seen;
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    #1;
    vectors++; if (core_reset !== 1'b1) begin errors++; $display("FAIL short_entry_core_reset got %0b want 1", core_reset); end
    tick;
    burst(0, 100, 8'h44, seen);
    ioctl_download = 1'b0;
    tick;
    vectors++; if (seen != 100) begin errors++; $display("FAIL short_pulses got %0d want 100", seen); end
    vectors++; if (rom_err !== 1'b1 || core_reset !== 1'b1) begin errors++; $display("FAIL short_err got rom_err=%0b core_reset=%0b want 1/1", rom_err, core_reset); end
    repeat (5) tick;
    vectors++; if (core_reset !== 1'b1) begin errors++; $display("FAIL short_idle_hold got %0b want 1", core_reset); end
  endtask

  task automatic test_rom_overflow;
    int seen;
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    tick;
    vectors++; if (rom_err !== 1'b0) begin errors++; $display("FAIL ovf_err_cleared got %0b want 0", rom_err); end
    burst(0, 16384, 8'h01, seen);
    vectors++; if (seen != 16384) begin errors++; $display("FAIL ovf_pulses got %0d want 16384", seen); end
    ioctl_wr = 1'b1; ioctl_addr = 25'h10000; ioctl_dout = 8'h99;
    tick;
    ioctl_wr = 1'b0;
    vectors++; if (dn_wr !== 1'b0) begin errors++; $display("FAIL ovf_dropped got dn_wr=%0b want 0", dn_wr); end
    ioctl_download = 1'b0;
    tick;
    vectors++; if (rom_err !== 1'b1 || core_reset !== 1'b1) begin errors++; $display("FAIL ovf_err got rom_err=%0b core_reset=%0b want 1/1", rom_err, core_reset); end
  endtask

  task automatic test_reset_midload;
    int seen;
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    tick;
    burst(0, 5000, 8'h77, seen);
    ioctl_wr = 1'b1; ioctl_addr = 25'd5000;
    I_RESET = 1'b1;
    #1;
    vectors++; if (core_reset !== 1'b1 || dn_wr !== 1'b0 || dn_addr !== 16'h0 || dn_data !== 8'h0) begin errors++; $display("FAIL midrst_dn got %0b/%0b/%h/%h want 1/0/0000/00", core_reset, dn_wr, dn_addr, dn_data); end
    vectors++; if (mod !== 8'h00 || dip0 !== 8'hFF || dip1 !== 8'hFF || dip2 !== 8'hFF || rom_err !== 1'b0 || rom_sum !== 8'h00) begin errors++; $display("FAIL midrst_regs got %h/%h/%h/%h/%0b/%h want 00/ff/ff/ff/0/00", mod, dip0, dip1, dip2, rom_err, rom_sum); end
    tick;
    I_RESET = 1'b0;
    burst(5001, 200, 8'h77, seen);
    vectors++; if (seen != 0 || core_reset !== 1'b1) begin errors++; $display("FAIL midrst_ignored got %0d pulses core_reset=%0b want 0/1", seen, core_reset); end
    ioctl_download = 1'b0;
    repeat (2) tick;
    vectors++; if (core_reset !== 1'b1 || rom_err !== 1'b0) begin errors++; $display("FAIL midrst_idle got core_reset=%0b rom_err=%0b want 1/0", core_reset, rom_err); end
  endtask

`ifdef ROMLOAD_CHECKSUM_EN
  task automatic test_checksum;
    int seen;
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    tick;
    burst(0, 16384, 8'h01, seen);
    vectors++; if (rom_sum !== 8'h00) begin errors++; $display("FAIL sum_16384 got %h want 00", rom_sum); end
    burst(16384, 1, 8'h01, seen);
    vectors++; if (rom_sum !== 8'h01) begin errors++; $display("FAIL sum_16385 got %h want 01", rom_sum); end
    ioctl_download = 1'b0;
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_rom_good;
    test_aux_dip;
    test_aux_mod;
    test_ignored_index;
    test_usr_reset;
    test_rom_short;
    test_rom_overflow;
    test_reset_midload;
`ifdef ROMLOAD_CHECKSUM_EN
    test_checksum;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
